// File: rtl/dest_sink_reader.sv
// Drains the D0/D1 destination FIFOs round-robin, presents one checked packet per cycle,
// and keeps saturating per-destination / VC1 counters plus a sticky routing-error flag.
module dest_sink_reader #(
    parameter int BW     = 6,
    parameter int RD_LAT = 1,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            enable,
    input  logic            D0_empty,
    input  logic            D1_empty,
    input  logic [BW-1:0]   D0_data_out,
    input  logic [BW-1:0]   D1_data_out,
    output logic            D0_rd,
    output logic            D1_rd,
    output logic            pkt_valid,
    output logic [BW-1:0]   pkt_data,
    output logic            pkt_src,
    output logic [CNTW-1:0] cnt_D0,
    output logic [CNTW-1:0] cnt_D1,
    output logic [CNTW-1:0] cnt_vc1,
    output logic            dest_error,
    output logic            drained
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic              rr;
    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] src_p;
    logic              pop_en;
    logic              pipe_busy;
    logic              exit_vld;
    logic              exit_src;
    logic [BW-1:0]     exit_data;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c, input logic inc);
        if (inc && (c != {CNTW{1'b1}}))
            return c + CNTW'(1);
        return c;
    endfunction

    // Pop request: rr only breaks the tie when both FIFOs have data.
    always_comb begin
        pop_en    = (state == RUN) && enable;
        D0_rd     = pop_en && !D0_empty && (!rr || D1_empty);
        D1_rd     = pop_en && !D1_empty && (rr || D0_empty);
        pipe_busy = |vld_p;
        exit_vld  = vld_p[RD_LAT-1];
        exit_src  = src_p[RD_LAT-1];
        exit_data = exit_src ? D1_data_out : D0_data_out;
        drained   = (state == IDLE) && !pipe_busy;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            rr         <= 1'b0;
            vld_p      <= '0;
            src_p      <= '0;
            pkt_valid  <= 1'b0;
            pkt_data   <= '0;
            pkt_src    <= 1'b0;
            cnt_D0     <= '0;
            cnt_D1     <= '0;
            cnt_vc1    <= '0;
            dest_error <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable)
                        state <= RUN;
                    else if (!pipe_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // After any pop the other FIFO gets priority next time.
            if (D0_rd || D1_rd)
                rr <= ~D1_rd;

            // ---- read-latency pipeline: index 0 is the newest pop ----
            vld_p <= (vld_p << 1) | RD_LAT'(D0_rd || D1_rd);
            src_p <= (src_p << 1) | RD_LAT'(D1_rd);

            // ---- capture stage: FIFO data is valid as the entry exits ----
            pkt_valid <= exit_vld;
            if (exit_vld) begin
                pkt_data <= exit_data;
                pkt_src  <= exit_src;
                cnt_D0   <= sat_inc(cnt_D0, !exit_src);
                cnt_D1   <= sat_inc(cnt_D1, exit_src);
                cnt_vc1  <= sat_inc(cnt_vc1, exit_data[BW-1]);
                if (exit_data[BW-2] != exit_src)
                    dest_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dest_sink_reader.sv
// Scoreboard bench for dest_sink_reader: FIFO emulation, cycle-level arbitration model,
// and a decoupled monitor comparing each delivered packet and the counters.
module tb_dest_sink_reader;
    localparam int BW     = 6;
    localparam int RD_LAT = 1;
    localparam int CNTW   = 4;
    localparam int CMAX   = (1 << CNTW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_L;
    logic            enable;
    logic            D0_empty = 1'b1;
    logic            D1_empty = 1'b1;
    logic [BW-1:0]   D0_data_out = '0;
    logic [BW-1:0]   D1_data_out = '0;
    logic            D0_rd, D1_rd, pkt_valid, pkt_src, dest_error, drained;
    logic [BW-1:0]   pkt_data;
    logic [CNTW-1:0] cnt_D0, cnt_D1, cnt_vc1;

    dest_sink_reader #(.BW(BW), .RD_LAT(RD_LAT), .CNTW(CNTW)) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
        .D0_rd(D0_rd), .D1_rd(D1_rd),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_src(pkt_src),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .cnt_vc1(cnt_vc1),
        .dest_error(dest_error), .drained(drained)
    );

    typedef struct packed {
        logic [BW-1:0] data;
        logic          src;
        int            due;
    } exp_t;

    logic [BW-1:0] f0[$], f1[$];   // contents of the emulated FIFOs
    logic [BW-1:0] m0[$], m1[$];   // reference model's view of the FIFOs
    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   ec0 = 0, ec1 = 0, ecv = 0;
    logic eerr = 1'b0;
    logic en_prev = 1'b0;
    logic rr_m = 1'b0;
    int   zero_run = RD_LAT + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push0(input logic [BW-1:0] v);
        f0.push_back(v);
        m0.push_back(v);
    endtask

    task automatic push1(input logic [BW-1:0] v);
        f1.push_back(v);
        m1.push_back(v);
    endtask

    function automatic int sat(input int v);
        return (v + 1 > CMAX) ? CMAX : v + 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO emulation: one-cycle read latency, empty reflects a pop from the next cycle.
    always @(posedge clk) begin
        if (D0_rd && f0.size() > 0) D0_data_out <= f0.pop_front();
        if (D1_rd && f1.size() > 0) D1_data_out <= f1.pop_front();
        D0_empty <= (f0.size() == 0);
        D1_empty <= (f1.size() == 0);
    end

    // Reference model: pops allowed only when enable held this cycle and the previous one.
    always @(negedge clk) begin
        logic exp0, exp1;
        exp_t e;
        if (!reset_L) begin
            chk("rd_in_reset", 64'({D1_rd, D0_rd}), 64'(0));
            en_prev  = 1'b0;
            rr_m     = 1'b0;
            zero_run = RD_LAT + 1;
        end else begin
            exp0 = 1'b0;
            exp1 = 1'b0;
            if (en_prev && enable) begin
                if (!D0_empty && !D1_empty) begin
                    if (rr_m) exp1 = 1'b1;
                    else      exp0 = 1'b1;
                end else if (!D0_empty) exp0 = 1'b1;
                else if (!D1_empty)     exp1 = 1'b1;
            end
            chk("rd_pattern", 64'({D1_rd, D0_rd}), 64'({exp1, exp0}));
            chk("drained", 64'(drained), 64'(zero_run >= RD_LAT + 1));
            if (exp0 || exp1) begin
                rr_m  = exp0;
                e.src = exp1;
                if (exp1) e.data = (m1.size() > 0) ? m1.pop_front() : '0;
                else      e.data = (m0.size() > 0) ? m0.pop_front() : '0;
                e.due = cyc + RD_LAT + 1;
                sb.push_back(e);
            end
            zero_run = enable ? 0 : ((zero_run < 8) ? zero_run + 1 : zero_run);
            en_prev  = enable;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a packet.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_L) begin
            sb.delete();
            ec0 = 0; ec1 = 0; ecv = 0; eerr = 1'b0;
            chk("reset_outputs",
                64'({pkt_valid, pkt_data, pkt_src, cnt_D0, cnt_D1, cnt_vc1, dest_error, drained}),
                64'(1));
        end else begin
            if (pkt_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_pkt_valid");
                end else begin
                    e = sb.pop_front();
                    chk("pkt_data", 64'(pkt_data), 64'(e.data));
                    chk("pkt_src", 64'(pkt_src), 64'(e.src));
                    chk("pkt_latency", 64'(cyc), 64'(e.due));
                    if (e.src) ec1 = sat(ec1);
                    else       ec0 = sat(ec0);
                    if (e.data[BW-1]) ecv = sat(ecv);
                    if (e.data[BW-2] != e.src) eerr = 1'b1;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                fail_now("missing_pkt_valid");
                void'(sb.pop_front());
            end
            chk("cnt_D0", 64'(cnt_D0), 64'(ec0));
            chk("cnt_D1", 64'(cnt_D1), 64'(ec1));
            chk("cnt_vc1", 64'(cnt_vc1), 64'(ecv));
            chk("dest_error", 64'(dest_error), 64'(eerr));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit seen;
        reset_L = 1'b0;
        enable  = 1'b0;
        tick(3);
        reset_L = 1'b1;
        tick(2);

        // In-order delivery from D0 alone.
        push0(6'h05); push0(6'h07);
        tick(2); enable = 1'b1; tick(8); enable = 1'b0; tick(4);
        @(negedge clk);
        chk("t1_cnt_D0", 64'(cnt_D0), 64'(2));
        chk("t1_dest_error", 64'(dest_error), 64'(0));

        // Both FIFOs loaded: alternating pops.
        push0(6'h01); push0(6'h02); push0(6'h03);
        push1(6'h11); push1(6'h12); push1(6'h13);
        tick(2); enable = 1'b1; tick(12); enable = 1'b0; tick(4);
        @(negedge clk);
        chk("t2_cnt_D0", 64'(cnt_D0), 64'(5));
        chk("t2_cnt_D1", 64'(cnt_D1), 64'(3));
        chk("t2_cnt_vc1", 64'(cnt_vc1), 64'(0));

        // Misrouted packet from D1, then a correct one: error stays set.
        push1(6'h20); push1(6'h11);
        tick(2); enable = 1'b1; tick(8); enable = 1'b0; tick(4);
        @(negedge clk);
        chk("t3_dest_error_sticky", 64'(dest_error), 64'(1));
        chk("t3_cnt_D1", 64'(cnt_D1), 64'(5));

        // Drop enable right after the first of four pops.
        push0(6'h01); push0(6'h02); push0(6'h03); push0(6'h04);
        tick(2); enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (D0_rd) seen = 1'b1;
            else tick(1);
        end
        if (!seen) fail_now("t4_no_pop_timeout");
        tick(1); enable = 1'b0; tick(6);
        @(negedge clk);
        chk("t4_left_in_D0", 64'(f0.size()), 64'(3));
        chk("t4_drained", 64'(drained), 64'(1));
        chk("t4_cnt_D0", 64'(cnt_D0), 64'(6));

        // Counter saturation and VC1 counting.
        tick(1);
        for (int i = 0; i < 12; i++) push0(6'(i));
        push1(6'h30); push1(6'h31);
        tick(2); enable = 1'b1; tick(30); enable = 1'b0; tick(4);
        @(negedge clk);
        chk("t5_cnt_D0_sat", 64'(cnt_D0), 64'(CMAX));
        chk("t5_cnt_vc1", 64'(cnt_vc1), 64'(3));
        chk("t5_cnt_D1", 64'(cnt_D1), 64'(7));

        // Reset with reads in flight, then round-robin restarts at D0.
        tick(1);
        push0(6'h01); push0(6'h02); push0(6'h03); push1(6'h15);
        tick(2); enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (D0_rd || D1_rd) seen = 1'b1;
            else tick(1);
        end
        if (!seen) fail_now("t6_no_pop_timeout");
        tick(1);
        reset_L = 1'b0;
        enable  = 1'b0;
        #1;
        chk("t6_async_reset_outputs",
            64'({pkt_valid, pkt_data, pkt_src, cnt_D0, cnt_D1, cnt_vc1, dest_error, drained}),
            64'(1));
        tick(2); reset_L = 1'b1; tick(4);
        push0(6'h04); push1(6'h16);
        tick(2); enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (D0_rd || D1_rd) seen = 1'b1;
            else tick(1);
        end
        if (!seen) fail_now("t6_rr_timeout");
        else chk("t6_first_pop_is_D0", 64'({D1_rd, D0_rd}), 64'(2'b01));
        tick(12); enable = 1'b0; tick(4);

        // Randomized traffic, enable toggling and occasional resets.
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && f0.size() < 8) push0(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0 && f1.size() < 8) push1(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 499) == 0) begin
                reset_L = 1'b0;
                tick(1);
                reset_L = 1'b1;
            end else begin
                tick(1);
            end
        end
        enable = 1'b0;
        tick(10);
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
